stack_call_seq: RTL and testbench

//  Multi-cycle sequencer for PUSH/POP/CALL/RET. Reads SP/LR/PC from the special register file, runs one

---
 rtl/stack_call_seq.sv | 214 +++++++++++++++++++++
 tb/tb_stack_call_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_call_seq.sv
// Stack/call sequencer: turns PUSH/POP/CALL/RET into one data-memory access
// followed by a single-cycle commit of SP/LR/PC updates to the special register file.
module stack_call_seq #(
  parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic [31:0] re_sp,
  input  logic [31:0] re_lr,
  input  logic [31:0] re_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wr_sp,
  output logic        wr_lr,
  output logic        wr_pc,
  output logic [31:0] wr_sp_data,
  output logic [31:0] wr_lr_data,
  output logic [31:0] wr_pc_data,
  output logic        pop_valid,
  output logic [31:0] pop_data,
  output logic        done,
  output logic        fault,
  input  logic        fault_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_PUSH = 2'd0, OP_POP = 2'd1, OP_CALL = 2'd2, OP_RET = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_COMMIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] data_q, data_d, sp_q, sp_d, lr_q, lr_d, pc_q, pc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        fault_q, fault_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        wr_sp_q, wr_sp_d, wr_lr_q, wr_lr_d, wr_pc_q, wr_pc_d;
  logic [31:0] wr_sp_data_q, wr_sp_data_d, wr_lr_data_q, wr_lr_data_d, wr_pc_data_q, wr_pc_data_d;
  logic        pop_valid_q, pop_valid_d, done_q, done_d;
  logic [31:0] pop_data_q, pop_data_d;

  // Stack bounds: writes need room for one more word, reads need a non-empty stack.
  function automatic logic sp_bad(input logic [1:0] op, input logic [31:0] sp);
    if (sp[1:0] != 2'b00) return 1'b1;
    if (op == OP_PUSH || op == OP_CALL) return sp < (STACK_LIMIT + 32'd4);
    return sp >= STACK_BASE;
  endfunction

  assign cmd_ready = (state_q == S_IDLE) && !fault_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    sp_d         = sp_q;
    lr_d         = lr_q;
    pc_d         = pc_q;
    tcnt_d       = tcnt_q;
    fault_d      = fault_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wr_sp_d      = 1'b0;
    wr_lr_d      = 1'b0;
    wr_pc_d      = 1'b0;
    wr_sp_data_d = wr_sp_data_q;
    wr_lr_data_d = wr_lr_data_q;
    wr_pc_data_d = wr_pc_data_q;
    pop_valid_d  = 1'b0;
    pop_data_d   = pop_data_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fault_q) begin
          if (fault_clr) fault_d = 1'b0;
        end else if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          sp_d   = re_sp;
          lr_d   = re_lr;
          pc_d   = re_pc;
          if (sp_bad(cmd_op, re_sp)) begin
            fault_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d     = S_MEM;
            tcnt_d      = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = (cmd_op == OP_PUSH) || (cmd_op == OP_CALL);
            mem_addr_d  = mem_we_d ? (re_sp - 32'd4) : re_sp;
            mem_wdata_d = (cmd_op == OP_CALL) ? re_lr : cmd_data;
          end
        end
      end

      S_MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_COMMIT;
          done_d    = 1'b1;
          wr_sp_d   = 1'b1;
          case (op_q)
            OP_PUSH: wr_sp_data_d = sp_q - 32'd4;
            OP_POP: begin
              wr_sp_data_d = sp_q + 32'd4;
              pop_valid_d  = 1'b1;
              pop_data_d   = mem_rdata;
            end
            OP_CALL: begin
              wr_sp_data_d = sp_q - 32'd4;
              wr_lr_d      = 1'b1;
              wr_lr_data_d = pc_q + 32'd4;
              wr_pc_d      = 1'b1;
              wr_pc_data_d = {data_q[31:2], 2'b00};
            end
            default: begin
              wr_sp_data_d = sp_q + 32'd4;
              wr_pc_d      = 1'b1;
              wr_pc_data_d = {lr_q[31:2], 2'b00};
              wr_lr_d      = 1'b1;
              wr_lr_data_d = mem_rdata;
            end
          endcase
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          // Memory never answered: abandon the command without touching registers.
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      data_q       <= '0;
      sp_q         <= '0;
      lr_q         <= '0;
      pc_q         <= '0;
      tcnt_q       <= '0;
      fault_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_sp_q      <= 1'b0;
      wr_lr_q      <= 1'b0;
      wr_pc_q      <= 1'b0;
      wr_sp_data_q <= '0;
      wr_lr_data_q <= '0;
      wr_pc_data_q <= '0;
      pop_valid_q  <= 1'b0;
      pop_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      sp_q         <= sp_d;
      lr_q         <= lr_d;
      pc_q         <= pc_d;
      tcnt_q       <= tcnt_d;
      fault_q      <= fault_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_sp_q      <= wr_sp_d;
      wr_lr_q      <= wr_lr_d;
      wr_pc_q      <= wr_pc_d;
      wr_sp_data_q <= wr_sp_data_d;
      wr_lr_data_q <= wr_lr_data_d;
      wr_pc_data_q <= wr_pc_data_d;
      pop_valid_q  <= pop_valid_d;
      pop_data_q   <= pop_data_d;
      done_q       <= done_d;
    end
  end

  assign fault      = fault_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_sp      = wr_sp_q;
  assign wr_lr      = wr_lr_q;
  assign wr_pc      = wr_pc_q;
  assign wr_sp_data = wr_sp_data_q;
  assign wr_lr_data = wr_lr_data_q;
  assign wr_pc_data = wr_pc_data_q;
  assign pop_valid  = pop_valid_q;
  assign pop_data   = pop_data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stack_call_seq.sv
// Randomized bench for stack_call_seq: a word-level stack/register model plays
// both the special register file and the data memory.
module tb_stack_call_seq;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = 32'h0000_0800;
  localparam int          TMO   = 16;
  localparam logic [1:0]  PUSH = 2'd0, POP = 2'd1, CALL = 2'd2, RET = 2'd3;

  logic        clk = 1'b0, reset = 1'b0;
  logic        cmd_valid = 1'b0, mem_ack = 1'b0, fault_clr = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = '0, re_sp = '0, re_lr = '0, re_pc = '0, mem_rdata = '0;
  logic        cmd_ready, mem_req, mem_we, wr_sp, wr_lr, wr_pc, pop_valid, done, fault;
  logic [31:0] mem_addr, mem_wdata, wr_sp_data, wr_lr_data, wr_pc_data, pop_data;

  int n_tests = 0, n_fail = 0;

  // Architectural model: register file contents and stack memory
  logic [31:0] m_sp, m_lr, m_pc;
  logic [31:0] bmem [logic [31:0]];

  stack_call_seq dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .re_sp(re_sp), .re_lr(re_lr), .re_pc(re_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wr_sp(wr_sp), .wr_lr(wr_lr), .wr_pc(wr_pc),
    .wr_sp_data(wr_sp_data), .wr_lr_data(wr_lr_data), .wr_pc_data(wr_pc_data),
    .pop_valid(pop_valid), .pop_data(pop_data), .done(done), .fault(fault),
    .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Issue one command from the model state, act as memory, check every cycle until IDLE again.
  task automatic test_cmd(input logic [1:0] op, input logic [31:0] d, input int dly,
                          input string nm, output logic faulted);
    logic bad, e_we, e_wsp, e_wlr, e_wpc, e_pv;
    logic [31:0] e_addr, e_wdata, n_sp, n_lr, n_pc, e_pop;
    bad = (m_sp[1:0] != 2'b00) ||
          (((op == PUSH) || (op == CALL)) ? (m_sp < LIMIT + 32'd4) : (m_sp >= BASE));
    e_wsp = 1'b1; e_wlr = 1'b0; e_wpc = 1'b0; e_pv = 1'b0;
    n_sp = m_sp; n_lr = m_lr; n_pc = m_pc; e_pop = 32'h0; e_wdata = 32'h0;
    case (op)
      PUSH: begin e_we = 1'b1; e_addr = m_sp - 32'd4; e_wdata = d; n_sp = m_sp - 32'd4; end
      POP: begin e_we = 1'b0; e_addr = m_sp; e_pop = mem_rd(m_sp); n_sp = m_sp + 32'd4; e_pv = 1'b1; end
      CALL: begin
        e_we = 1'b1; e_addr = m_sp - 32'd4; e_wdata = m_lr; n_sp = m_sp - 32'd4;
        n_lr = m_pc + 32'd4; n_pc = d & 32'hFFFF_FFFC; e_wlr = 1'b1; e_wpc = 1'b1;
      end
      default: begin
        e_we = 1'b0; e_addr = m_sp; e_pop = mem_rd(m_sp); n_sp = m_sp + 32'd4;
        n_pc = m_lr & 32'hFFFF_FFFC; n_lr = e_pop; e_wlr = 1'b1; e_wpc = 1'b1;
      end
    endcase

    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready: got %b, expected 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; re_sp = m_sp; re_lr = m_lr; re_pc = m_pc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = $urandom;
    re_sp = $urandom; re_lr = $urandom; re_pc = $urandom;

    if (bad) begin
      n_tests++;
      if ({done, fault, mem_req, wr_sp, wr_lr, wr_pc, pop_valid} !== 7'b1100000) begin
        n_fail++;
        $display("FAIL %s reject: done/fault/req/wsp/wlr/wpc/pv=%b, expected 1100000", nm,
                 {done, fault, mem_req, wr_sp, wr_lr, wr_pc, pop_valid});
      end
      @(posedge clk); #1;
      n_tests++;
      if ({done, fault, cmd_ready, mem_req} !== 4'b0100) begin
        n_fail++;
        $display("FAIL %s post-reject: done/fault/ready/req=%b, expected 0100", nm,
                 {done, fault, cmd_ready, mem_req});
      end
      faulted = 1'b1;
      return;
    end

    for (int k = 0; k < TMO; k++) begin
      n_tests++;
      if (mem_req !== 1'b1 || mem_we !== e_we || mem_addr !== e_addr ||
          (e_we && mem_wdata !== e_wdata)) begin
        n_fail++;
        $display("FAIL %s mem cyc%0d: req=%b we=%b addr=%h wdata=%h, expected req=1 we=%b addr=%h wdata=%h",
                 nm, k, mem_req, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
      end
      if (k == dly) begin
        mem_ack = 1'b1;
        mem_rdata = mem_we ? $urandom : mem_rd(mem_addr);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (k == dly) break;
    end

    if (dly >= TMO) begin
      n_tests++;
      if ({done, fault, mem_req, wr_sp, wr_lr, wr_pc, pop_valid} !== 7'b1100000) begin
        n_fail++;
        $display("FAIL %s timeout: done/fault/req/wsp/wlr/wpc/pv=%b, expected 1100000", nm,
                 {done, fault, mem_req, wr_sp, wr_lr, wr_pc, pop_valid});
      end
      faulted = 1'b1;
      return;
    end

    // Commit cycle
    n_tests++;
    if ({done, mem_req, wr_sp, wr_lr, wr_pc, pop_valid} !== {2'b10, e_wsp, e_wlr, e_wpc, e_pv}) begin
      n_fail++;
      $display("FAIL %s strobes: done/req/wsp/wlr/wpc/pv=%b, expected %b", nm,
               {done, mem_req, wr_sp, wr_lr, wr_pc, pop_valid}, {2'b10, e_wsp, e_wlr, e_wpc, e_pv});
    end
    n_tests++;
    if (wr_sp_data !== n_sp) begin
      n_fail++; $display("FAIL %s wr_sp_data: got %h, expected %h", nm, wr_sp_data, n_sp);
    end
    if (e_wlr) begin
      n_tests++;
      if (wr_lr_data !== n_lr) begin
        n_fail++; $display("FAIL %s wr_lr_data: got %h, expected %h", nm, wr_lr_data, n_lr);
      end
    end
    if (e_wpc) begin
      n_tests++;
      if (wr_pc_data !== n_pc) begin
        n_fail++; $display("FAIL %s wr_pc_data: got %h, expected %h", nm, wr_pc_data, n_pc);
      end
    end
    if (e_pv) begin
      n_tests++;
      if (pop_data !== e_pop) begin
        n_fail++; $display("FAIL %s pop_data: got %h, expected %h", nm, pop_data, e_pop);
      end
    end
    if (op == PUSH) bmem[n_sp] = d;
    if (op == CALL) bmem[n_sp] = m_lr;
    m_sp = n_sp; m_lr = n_lr; m_pc = n_pc;

    @(posedge clk); #1;
    n_tests++;
    if ({done, wr_sp, wr_lr, wr_pc, pop_valid, mem_req, cmd_ready, fault} !== 8'b00000010) begin
      n_fail++;
      $display("FAIL %s after commit: done/wsp/wlr/wpc/pv/req/ready/fault=%b, expected 00000010", nm,
               {done, wr_sp, wr_lr, wr_pc, pop_valid, mem_req, cmd_ready, fault});
    end
    faulted = 1'b0;
  endtask

  task automatic clear_fault(input string nm);
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    n_tests++;
    if ({fault, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL %s clear: fault/ready=%b, expected 01", nm, {fault, cmd_ready});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({mem_req, done, fault, wr_sp, wr_lr, wr_pc, pop_valid, cmd_ready} !== 8'b00000001) begin
      n_fail++;
      $display("FAIL reset ctrl: req/done/fault/wsp/wlr/wpc/pv/ready=%b, expected 00000001",
               {mem_req, done, fault, wr_sp, wr_lr, wr_pc, pop_valid, cmd_ready});
    end
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata, wr_sp_data, wr_lr_data, wr_pc_data, pop_data} !== '0) begin
      n_fail++;
      $display("FAIL reset data: addr=%h wdata=%h sp=%h lr=%h pc=%h pop=%h, expected all 0",
               mem_addr, mem_wdata, wr_sp_data, wr_lr_data, wr_pc_data, pop_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop();
    logic f;
    m_sp = BASE; m_lr = 32'h40; m_pc = 32'h100;
    test_cmd(PUSH, 32'hDEADBEEF, 0, "t1_push", f);
    test_cmd(POP, 32'h0, 0, "t2_pop", f);
  endtask

  task automatic test_call_ret();
    logic f;
    m_sp = BASE; m_lr = 32'h40; m_pc = 32'h100;
    test_cmd(CALL, 32'h203, 0, "t3_call", f);
    test_cmd(RET, 32'h0, 1, "t3_ret", f);
    n_tests++;
    if ({m_sp, m_lr, m_pc} !== {BASE, 32'h40, 32'h104}) begin
      n_fail++; $display("FAIL t3 model regs: sp=%h lr=%h pc=%h, expected 1000 40 104", m_sp, m_lr, m_pc);
    end
  endtask

  task automatic test_underflow_fault();
    logic f;
    m_sp = BASE;
    test_cmd(POP, 32'h0, 0, "t4_pop_empty", f);
    // Command while faulted must be ignored, not queued.
    cmd_valid = 1'b1; cmd_op = PUSH; re_sp = BASE;
    @(posedge clk); #1;
    n_tests++;
    if ({mem_req, fault, cmd_ready, done} !== 4'b0100) begin
      n_fail++; $display("FAIL t4 ignored: req/fault/ready/done=%b, expected 0100", {mem_req, fault, cmd_ready, done});
    end
    // Clear and command together: clear now, command only next cycle.
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0; cmd_valid = 1'b0;
    n_tests++;
    if ({mem_req, fault, cmd_ready} !== 3'b001) begin
      n_fail++; $display("FAIL t4 clr+cmd: req/fault/ready=%b, expected 001", {mem_req, fault, cmd_ready});
    end
  endtask

  task automatic test_limits();
    logic f;
    m_sp = 32'h800;
    test_cmd(PUSH, 32'h1111, 0, "t5_push_full", f);
    clear_fault("t5a");
    m_sp = 32'hFFE;
    test_cmd(PUSH, 32'h2222, 0, "t5_misaligned", f);
    clear_fault("t5b");
    m_sp = 32'h804;
    test_cmd(PUSH, 32'h3333, 2, "t5_push_last", f);
  endtask

  task automatic test_timeout();
    logic f;
    m_sp = BASE;
    test_cmd(PUSH, 32'h5555, TMO, "t6_timeout", f);
    clear_fault("t6");
    test_cmd(PUSH, 32'h6666, TMO - 1, "t6_late_ack", f);
  endtask

  task automatic test_reset_mid_mem();
    cmd_valid = 1'b1; cmd_op = CALL; cmd_data = 32'h300; re_sp = m_sp; re_lr = m_lr; re_pc = m_pc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL t6 pre-reset req: got %b, expected 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, done, fault, wr_sp, wr_lr, wr_pc, pop_valid, mem_addr, mem_wdata, pop_data,
         wr_sp_data, wr_lr_data, wr_pc_data} !== '0) begin
      n_fail++;
      $display("FAIL t6 async reset: req=%b done=%b fault=%b addr=%h wdata=%h pop=%h, expected all 0",
               mem_req, done, fault, mem_addr, mem_wdata, pop_data);
    end
    #1 reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if ({mem_req, done, wr_sp, wr_lr, wr_pc, cmd_ready} !== 6'b000001) begin
        n_fail++;
        $display("FAIL t6 after reset: req/done/wsp/wlr/wpc/ready=%b, expected 000001",
                 {mem_req, done, wr_sp, wr_lr, wr_pc, cmd_ready});
      end
    end
  endtask

  task automatic test_random_back_to_back();
    logic f;
    logic [1:0] op;
    int dly;
    m_sp = BASE - 32'd16; m_lr = 32'h80; m_pc = 32'h400;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 1);
      test_cmd(op, $urandom, dly, "rand", f);
      if (f) clear_fault("rand");
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_call_ret();
    test_underflow_fault();
    test_limits();
    test_timeout();
    test_reset_mid_mem();
    test_random_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
